// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
//
// Contents:
//   DEF_WIDTH      default divisor/remainder width (dividend/quotient are twice this)
//   div_state_e    FSM state encoding (FIXUP is only used by the signed build)
//   cnt_width()    iteration-counter width for a given WIDTH: clog2(2*WIDTH)+1
//   CNT_W          counter width for the default WIDTH
//   DIV0_QUOTIENT  quotient reported for a zero divisor (all ones)
package div_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } div_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(2 * width) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

    localparam logic [2*DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of the restoring divider.
//
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor and keeps the difference when it is non-negative.
//
// Ports:
//   i_rem        partial remainder entering this iteration (always < divisor)
//   i_shift_bit  next dividend bit, MSB first
//   i_divisor    divisor magnitude
//   o_rem        partial remainder leaving this iteration
//   o_q_bit      quotient bit produced by this iteration
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_shift_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    // The shifted remainder needs WIDTH+1 bits; the stored one never does,
    // because it is always strictly below the divisor.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_shifted = {i_rem, i_shift_bit};
        w_trial   = w_shifted - {1'b0, i_divisor};
        // MSB of the WIDTH+1-bit difference is the borrow: set means negative.
        o_q_bit   = ~w_trial[WIDTH];
        o_rem     = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div64_32_seq.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
//
// Build option: define DIV_SIGNED_EN for two's complement operands. Magnitudes
// are divided and a FIXUP cycle applies the signs (quotient truncates toward
// zero, remainder follows the dividend). Without it the block is unsigned only.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     operands present
//   in_ready     block idle and able to accept
//   dividend     numerator, sampled on accept
//   divisor      denominator, sampled on accept
//   out_valid    result registers hold a completed result
//   out_ready    consumer takes the result
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered; set with a result whose divisor was zero
module div64_32_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int unsigned        CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]      LAST_ITER = CW'(2 * WIDTH - 1);
    localparam logic [2*WIDTH-1:0] DIV0_Q    = {(2 * WIDTH){DIV0_QUOTIENT[0]}};

    div_state_e         r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    // Dividend shifts out of the MSB while quotient bits shift into the LSB.
    logic [2*WIDTH-1:0] r_work, w_work_nxt;
    logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic [2*WIDTH-1:0] r_quot, w_quot_nxt;
    logic [WIDTH-1:0]   r_remd, w_remd_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_dbz, w_dbz_nxt;

    logic [2*WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_q_bit;

`ifdef DIV_SIGNED_EN
    logic r_neg_q, w_neg_q_nxt;
    logic r_neg_r, w_neg_r_nxt;

    assign w_dvd_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem       (r_rem),
        .i_shift_bit (r_work[2*WIDTH-1]),
        .i_divisor   (r_dvs),
        .o_rem       (w_step_rem),
        .o_q_bit     (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_remd      <= '0;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_work      <= w_work_nxt;
            r_dvs       <= w_dvs_nxt;
            r_rem       <= w_rem_nxt;
            r_quot      <= w_quot_nxt;
            r_remd      <= w_remd_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_dbz       <= w_dbz_nxt;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= w_neg_q_nxt;
            r_neg_r     <= w_neg_r_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_work_nxt      = r_work;
        w_dvs_nxt       = r_dvs;
        w_rem_nxt       = r_rem;
        w_quot_nxt      = r_quot;
        w_remd_nxt      = r_remd;
        w_out_valid_nxt = r_out_valid;
        w_dbz_nxt       = r_dbz;
`ifdef DIV_SIGNED_EN
        w_neg_q_nxt     = r_neg_q;
        w_neg_r_nxt     = r_neg_r;
`endif

        case (r_state)
            IDLE: begin
                // in_ready is high here, so in_valid alone is an accept.
                if (in_valid) begin
                    w_work_nxt = w_dvd_mag;
                    w_dvs_nxt  = w_dvs_mag;
                    w_rem_nxt  = '0;
                    w_cnt_nxt  = '0;
`ifdef DIV_SIGNED_EN
                    w_neg_q_nxt = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                    w_neg_r_nxt = dividend[2*WIDTH-1];
`endif
                    if (divisor == '0) begin
                        w_quot_nxt      = DIV0_Q;
                        w_remd_nxt      = dividend[WIDTH-1:0];
                        w_dbz_nxt       = 1'b1;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = DONE;
                    end else begin
                        w_dbz_nxt   = 1'b0;
                        w_state_nxt = CALC;
                    end
                end
            end

            CALC: begin
                w_work_nxt = {r_work[2*WIDTH-2:0], w_q_bit};
                w_rem_nxt  = w_step_rem;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_quot_nxt = {r_work[2*WIDTH-2:0], w_q_bit};
                    w_remd_nxt = w_step_rem;
`ifdef DIV_SIGNED_EN
                    w_state_nxt = FIXUP;
`else
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            FIXUP: begin
                // Most-negative / -1 wraps back to most-negative here.
                w_quot_nxt      = r_neg_q ? -r_quot : r_quot;
                w_remd_nxt      = r_neg_r ? -r_remd : r_remd;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = DONE;
            end
`endif

            DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div64_32_seq.sv
// Self-checking bench for div64_32_seq: directed vector table, hand-written
// backpressure and mid-operation reset sequences, and randomized operations
// checked against a plain-arithmetic reference model.
module tb_div64_32_seq;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 2 * W + 2;
`else
    localparam int LAT = 2 * W + 1;
`endif
    localparam int MAX_WAIT = 200;
    localparam int N_RAND   = 200;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [63:0] dvd;
        logic [31:0] dvs;
        logic [63:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div64_32_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain division with the signed/zero-divisor rules.
    function automatic void ref_div(input logic [63:0] dvd, input logic [31:0] dvs,
                                    output logic [63:0] q, output logic [31:0] r,
                                    output logic dbz);
        longint sd, sv, sq, sr;
        logic [63:0] r64;
        sd  = 0;
        sv  = 0;
        sq  = 0;
        sr  = 0;
        r64 = 0;
        dbz = (dvs == 32'd0);
        if (dbz) begin
            q = '1;
            r = dvd[31:0];
        end else begin
`ifdef DIV_SIGNED_EN
            if (dvd == 64'h8000_0000_0000_0000 && dvs == 32'hFFFF_FFFF) begin
                q = dvd;
                r = 32'd0;
            end else begin
                sd = longint'(dvd);
                sv = longint'(signed'(dvs));
                sq = sd / sv;
                sr = sd % sv;
                q  = 64'(sq);
                r64 = 64'(sr);
                r  = r64[31:0];
            end
`else
            q   = dvd / {32'd0, dvs};
            r64 = dvd % {32'd0, dvs};
            r   = r64[31:0];
`endif
        end
    endfunction

    task automatic add_vec(input string name, input logic [63:0] dvd, input logic [31:0] dvs,
                           input logic [63:0] q, input logic [31:0] r, input logic dbz,
                           input int lat);
        vec_t v;
        v.name = name;
        v.dvd  = dvd;
        v.dvs  = dvs;
        v.q    = q;
        v.r    = r;
        v.dbz  = dbz;
        v.lat  = lat;
        vecs.push_back(v);
    endtask

    // Called at posedge+1 with the block idle; leaves it idle again.
    task automatic run_op(input string name, input logic [63:0] dvd, input logic [31:0] dvs,
                          input logic [63:0] eq, input logic [31:0] er, input logic edbz,
                          input int elat);
        int lat;
        chk({name, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " out_valid"}, 64'(out_valid), 64'd1);
        chk({name, " latency"}, 64'(lat), 64'(elat));
        chk({name, " quotient"}, quotient, eq);
        chk({name, " remainder"}, 64'(remainder), 64'(er));
        chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " taken"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] rq;
        logic [31:0] rr;
        logic        rdbz;
        logic [63:0] rdvd;
        logic [31:0] rdvs;
        int          n;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

`ifdef DIV_SIGNED_EN
        add_vec("s_pos", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, LAT);
        add_vec("s_negdvd", 64'hFFFF_FFFF_FFFF_FF9C, 32'd7,
                64'hFFFF_FFFF_FFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT);
        add_vec("s_negdvs", 64'd100, 32'hFFFF_FFF9,
                64'hFFFF_FFFF_FFFF_FFF2, 32'd2, 1'b0, LAT);
        add_vec("s_bothneg", 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9,
                64'd14, 32'hFFFF_FFFE, 1'b0, LAT);
        add_vec("s_minneg1", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF,
                64'h8000_0000_0000_0000, 32'd0, 1'b0, LAT);
        add_vec("s_m1m1", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 32'd0, 1'b0, LAT);
        add_vec("s_div0", 64'd1234, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h4D2, 1'b1, 1);
`else
        add_vec("basic", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, LAT);
        add_vec("full", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,
                64'h0000_0001_0000_0001, 32'd0, 1'b0, LAT);
        add_vec("by_one", 64'h0001_0000_0000_0000, 32'd1,
                64'h0001_0000_0000_0000, 32'd0, 1'b0, LAT);
        add_vec("div0", 64'd1234, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h4D2, 1'b1, 1);
        add_vec("zero_dvd", 64'd0, 32'd5, 64'd0, 32'd0, 1'b0, LAT);
        add_vec("small", 64'd5, 32'd10, 64'd0, 32'd5, 1'b0, LAT);
        add_vec("max_by_2", 64'hFFFF_FFFF_FFFF_FFFF, 32'd2,
                64'h7FFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, LAT);
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", 64'(remainder), 64'd0);
        chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
                   vecs[i].dbz, vecs[i].lat);
        end

        // Backpressure: result held while out_ready is low, new input ignored.
        in_valid = 1'b1;
        dividend = 64'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp out_valid", 64'(out_valid), 64'd1);
        dividend = 64'd77;
        divisor  = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp held quotient", quotient, 64'd333);
            chk("bp held remainder", 64'(remainder), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp held out_valid", 64'(out_valid), 64'd1);
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp taken out_valid", 64'(out_valid), 64'd0);
        chk("bp idle in_ready", 64'(in_ready), 64'd1);
        chk("bp kept quotient", quotient, 64'd333);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second accepted", 64'(in_ready), 64'd0);
        n = 1;
        while (!out_valid && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp second latency", 64'(n), 64'(LAT));
        chk("bp second quotient", quotient, 64'd15);
        chk("bp second remainder", 64'(remainder), 64'd2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of an operation.
        in_valid = 1'b1;
        dividend = 64'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst quotient", quotient, 64'd0);
        chk("rst remainder", 64'(remainder), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst released in_ready", 64'(in_ready), 64'd1);
        chk("rst no stray result", 64'(out_valid), 64'd0);
        run_op("after_rst", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, LAT);

        // Randomized operations against the reference model.
        for (int k = 0; k < N_RAND; k++) begin
            case ($urandom_range(0, 3))
                0:       rdvd = {32'd0, 32'($urandom)};
                1:       rdvd = 64'($urandom_range(0, 1000));
                default: rdvd = {32'($urandom), 32'($urandom)};
            endcase
            n = int'($urandom_range(0, 15));
            if (n == 0) rdvs = 32'd0;
            else if (n < 6) rdvs = 32'($urandom_range(1, 20));
            else rdvs = 32'($urandom);
            ref_div(rdvd, rdvs, rq, rr, rdbz);
            run_op("random", rdvd, rdvs, rq, rr, rdbz, rdbz ? 1 : LAT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
